// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: operation codes and FSM state type shared by the execute-stage ALU.
// Rev 1.0
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_INV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } alu_state_t;
endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// alu_mul_iter: shift-add unsigned multiplier, one partial-product step per clock.
// Rev 1.0 -- only instantiated when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_next,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    count;

  assign busy = (count != '0);
  // done flags the final step so the caller can capture the finished product this cycle
  assign done = (count == CW'(1));
  assign product_next = product + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      count   <= '0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      product <= '0;
      count   <= CW'(WIDTH);
    end else if (busy) begin
      product <= product_next;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count - 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// alu_exec: registered execute-stage ALU with valid/ready handshake on both sides.
// Rev 1.0 -- define ALU_MUL_EN to enable the iterative multiply on code 0011.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);
  logic             slot_free;
  logic             deliver;
  logic             accept;
  logic [WIDTH-1:0] op_result;
  logic             op_illegal;

  // slot_free includes the draining case so a new result can replace the old one on the same edge
  assign slot_free = !out_valid || out_ready;
  assign deliver   = out_valid && out_ready;
  assign accept    = in_valid && in_ready;
  assign zero      = (result == '0);

  always_comb begin
    op_result  = '0;
    op_illegal = 1'b0;
    case (alu_ctrl)
      ALU_AND: op_result = src_a & src_b;
      ALU_OR:  op_result = src_a | src_b;
      ALU_ADD: op_result = src_a + src_b;
      ALU_SUB: op_result = src_a - src_b;
`ifdef ALU_MUL_EN
      ALU_MUL: op_result = '0;
`endif
      default: op_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t       state;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH-1:0] mul_prod;

  assign in_ready  = (state == IDLE) && slot_free;
  assign mul_start = accept && (alu_ctrl == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .a            (src_a),
    .b            (src_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product_next (mul_next),
    .product      (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else begin
      if (deliver) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (mul_start) begin
              state <= MUL;
            end else begin
              out_valid <= 1'b1;
              result    <= op_result;
              illegal   <= op_illegal;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            if (slot_free) begin
              out_valid <= 1'b1;
              result    <= mul_next;
              illegal   <= 1'b0;
              state     <= IDLE;
            end else begin
              state <= HOLD;
            end
          end else if (!mul_busy) begin
            state <= IDLE;
          end
        end
        HOLD: begin
          // the multiplier register keeps the finished product until the slot frees up
          if (slot_free) begin
            out_valid <= 1'b1;
            result    <= mul_prod;
            illegal   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = slot_free;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else begin
      if (deliver) out_valid <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        result    <= op_result;
        illegal   <= op_illegal;
      end
    end
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// tb_alu_exec: directed vectors with a queue scoreboard; expectations follow ALU_MUL_EN.
// Rev 1.0
module tb_alu_exec;
  import alu_pkg::*;

  localparam int WIDTH = 32;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = WIDTH;
`else
  localparam int MUL_LAT = 0;
`endif

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [3:0]       alu_ctrl  = 4'h0;
  logic [WIDTH-1:0] src_a     = '0;
  logic [WIDTH-1:0] src_b     = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ill;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic i);
    exp_t e;
    e.res = r;
    e.ill = i;
    return e;
  endfunction

  // hand-computed product when the multiplier exists, otherwise an illegal-op response
  function automatic exp_t mul_exp(input logic [WIDTH-1:0] prod);
`ifdef ALU_MUL_EN
    return mk(prod, 1'b0);
`else
    return mk('0, 1'b1);
`endif
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input exp_t e, output int waited);
    in_valid = 1'b1;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", WIDTH'(in_ready), WIDTH'(1));
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h, expected no output", result);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("zero", WIDTH'(zero), WIDTH'(e.res == '0));
        chk("illegal", WIDTH'(illegal), WIDTH'(e.ill));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stalls;
    int cnt;
    int rdy_seen;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", WIDTH'(out_valid), '0);
    chk("reset_result", result, '0);
    chk("reset_zero", WIDTH'(zero), WIDTH'(1));
    chk("reset_illegal", WIDTH'(illegal), '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 1'b0), w);
    chk("add_latency", WIDTH'(out_valid), WIDTH'(1));
    send(ALU_SUB, 32'd5, 32'd5, mk(32'd0, 1'b0), w);
    chk("sub_latency", WIDTH'(out_valid), WIDTH'(1));

    stalls = 0;
    send(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, mk(32'h00F0_1234, 1'b0), w); stalls += w;
    send(ALU_OR,  32'h1234_0000, 32'h0000_5678, mk(32'h1234_5678, 1'b0), w); stalls += w;
    send(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0002, mk(32'h0000_0001, 1'b0), w); stalls += w;
    send(ALU_SUB, 32'h0000_0000, 32'h0000_0001, mk(32'hFFFF_FFFF, 1'b0), w); stalls += w;
    chk("b2b_in_ready_stalls", WIDTH'(stalls), '0);
    @(posedge clk);
    #1;

    // back-pressure: hold the consumer off while another op waits at the input
    out_ready = 1'b0;
    send(ALU_ADD, 32'd10, 32'd20, mk(32'd30, 1'b0), w);
    in_valid = 1'b1;
    alu_ctrl = ALU_ADD;
    src_a    = 32'd1;
    src_b    = 32'd1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", WIDTH'(in_ready), '0);
      chk("stall_out_valid", WIDTH'(out_valid), WIDTH'(1));
      chk("stall_result", result, 32'd30);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", WIDTH'(in_ready), WIDTH'(1));
    exp_q.push_back(mk(32'd2, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    send(ALU_INV, 32'h1234_5678, 32'h1, mk(32'd0, 1'b1), w);
    chk("inv_latency", WIDTH'(out_valid), WIDTH'(1));
    send(4'b0101, 32'hDEAD_BEEF, 32'h2, mk(32'd0, 1'b1), w);
    chk("code0101_latency", WIDTH'(out_valid), WIDTH'(1));

    send(ALU_MUL, 32'hFFFF_FFFF, 32'h0000_0003, mul_exp(32'hFFFF_FFFD), w);
    cnt = 0;
    rdy_seen = 0;
    while (!out_valid && cnt < 100) begin
      if (in_ready) rdy_seen++;
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("mul_latency", WIDTH'(cnt), WIDTH'(MUL_LAT));
    chk("mul_in_ready_low", WIDTH'(rdy_seen), '0);
    @(posedge clk);
    #1;

    // multiply waits behind an unconsumed result, then its own result is held
    out_ready = 1'b0;
    send(ALU_ADD, 32'd1, 32'd2, mk(32'd3, 1'b0), w);
    in_valid = 1'b1;
    alu_ctrl = ALU_MUL;
    src_a    = 32'd7;
    src_b    = 32'd6;
    repeat (2) begin
      @(negedge clk);
      chk("mul_wait_in_ready", WIDTH'(in_ready), '0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mul_accept_ready", WIDTH'(in_ready), WIDTH'(1));
    exp_q.push_back(mul_exp(32'd42));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    repeat (3) begin
      @(negedge clk);
      chk("held_out_valid", WIDTH'(out_valid), WIDTH'(1));
      chk("held_result", result, mul_exp(32'd42).res);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // reset before the tenth multiplier step discards the multiply
    send(ALU_MUL, 32'd12345, 32'd678, mul_exp(32'h007F_B6F6), w);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midmul_reset_out_valid", WIDTH'(out_valid), '0);
    chk("midmul_reset_zero", WIDTH'(zero), WIDTH'(1));
    rst_n = 1'b1;
    @(negedge clk);
    chk("midmul_in_ready", WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk);
    #1;
    send(ALU_ADD, 32'd2, 32'd3, mk(32'd5, 1'b0), w);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("queue_drained", WIDTH'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
